// File: rtl/repeat_iogroup_bank_pkg.sv
// Shared constants for the repeated iogroup register bank: word offsets
// inside a channel group, STATUS bit positions and a clog2 helper.
package repeat_iogroup_bank_pkg;

  localparam int AREG_OFS   = 0;
  localparam int STATUS_OFS = 1;

  localparam int LIVE_F0   = 0;
  localparam int LIVE_F1   = 1;
  localparam int STICKY_F0 = 2;
  localparam int STICKY_F1 = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/repeat_iogroup_bank_chan.sv
// One channel group: RW control register with write strobe, edge detect on
// the two event inputs and sticky rising-edge flags cleared by writing 1.
module repeat_iogroup_bank_chan
  import repeat_iogroup_bank_pkg::*;
#(
  parameter logic [31:0] AREG_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        areg_we,
  input  logic        status_we,
  input  logic [31:0] wdat,
  input  logic [1:0]  evt,
  output logic [31:0] areg,
  output logic        areg_wr,
  output logic [31:0] status,
  output logic [1:0]  sticky
);

  logic [31:0] areg_r;
  logic        areg_wr_r;
  logic [1:0]  prev_r;
  logic [1:0]  sticky_r;
  logic [1:0]  clr_s;
  logic [1:0]  rise_s;

  // Clear mask from a STATUS write; only the sticky bit positions matter.
  always_comb begin
    clr_s = 2'b00;
    if (status_we) begin
      clr_s = {wdat[STICKY_F1], wdat[STICKY_F0]};
    end else begin
      clr_s = 2'b00;
    end
  end

  assign rise_s = evt & ~prev_r;

  // Control register and its one-cycle write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg_r    <= AREG_RST;
      areg_wr_r <= 1'b0;
    end else begin
      areg_wr_r <= areg_we;
      if (areg_we) begin
        areg_r <= wdat;
      end
    end
  end

  // Edge history and sticky flags; a rising edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r   <= 2'b00;
      sticky_r <= 2'b00;
    end else begin
      prev_r   <= evt;
      sticky_r <= (sticky_r & ~clr_s) | rise_s;
    end
  end

  // STATUS word: live levels plus sticky flags, upper bits zero.
  always_comb begin
    status            = 32'd0;
    status[LIVE_F0]   = evt[0];
    status[LIVE_F1]   = evt[1];
    status[STICKY_F0] = sticky_r[0];
    status[STICKY_F1] = sticky_r[1];
  end

  assign areg    = areg_r;
  assign areg_wr = areg_wr_r;
  assign sticky  = sticky_r;

endmodule

// File: rtl/repeat_iogroup_bank.sv
// Pipelined Wishbone register bank for N_CHAN repeated channel groups.
// Word 2c is channel c control (RW), word 2c+1 its STATUS (live + W1C sticky).
// Reads ack one cycle after acceptance, writes two cycles after; unmapped
// channel indices answer with wb_err_o and read data 0.
// Optional macro REPEAT_IOGROUP_BANK_IRQ_EN adds irq_o (OR of sticky flags).
module repeat_iogroup_bank
  import repeat_iogroup_bank_pkg::*;
#(
  parameter int          N_CHAN   = 4,
  parameter logic [31:0] AREG_RST = 32'h0000_0000,
  localparam int         ADR_W    = clog2(N_CHAN) + 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [ADR_W-1:2]      wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  wb_stall_o,
  output logic [31:0]           wb_dat_o,
  output logic [32*N_CHAN-1:0]  chan_areg_o,
  output logic [N_CHAN-1:0]     chan_areg_wr_o,
  input  logic [2*N_CHAN-1:0]   chan_evt_i
`ifdef REPEAT_IOGROUP_BANK_IRQ_EN
  ,
  output logic                  irq_o
`endif
);

  localparam int IDX_W = (ADR_W > 3) ? ADR_W - 3 : 1;

  logic              wb_en_s;
  logic              rd_req_s;
  logic              wr_req_s;
  logic              done_s;
  logic              rip_r;
  logic              wip_r;
  logic              ack_r;
  logic              err_r;
  logic [31:0]       dat_r;
  logic [IDX_W-1:0]  adr_idx_s;
  logic              adr_map_s;
  logic [31:0]       rd_dat_s;
  logic              d0_vld_r;
  logic              d0_map_r;
  logic              d0_word_r;
  logic [IDX_W-1:0]  d0_idx_r;
  logic [31:0]       d0_dat_r;
  logic [N_CHAN-1:0] areg_we_s;
  logic [N_CHAN-1:0] status_we_s;
  logic [31:0]       status_s [N_CHAN];
  logic [2*N_CHAN-1:0] sticky_s;
  logic              unused_sel_s;

  assign unused_sel_s = ^wb_sel_i;

  if (ADR_W > 3) begin : g_idx
    assign adr_idx_s = wb_adr_i[ADR_W-1:3];
  end else begin : g_idx_single
    assign adr_idx_s = 1'b0;
  end

  assign wb_en_s    = wb_cyc_i & wb_stb_i;
  assign done_s     = ack_r | err_r;
  assign rd_req_s   = wb_en_s & ~wb_we_i & ~rip_r & ~wip_r;
  assign wr_req_s   = wb_en_s &  wb_we_i & ~rip_r & ~wip_r;
  assign wb_stall_o = ~done_s & wb_en_s;
  assign wb_rty_o   = 1'b0;
  assign wb_ack_o   = ack_r;
  assign wb_err_o   = err_r;
  assign wb_dat_o   = dat_r;

  // Address decode and read mux for the current request.
  always_comb begin
    adr_map_s = 1'b0;
    rd_dat_s  = 32'd0;
    for (int c = 0; c < N_CHAN; c++) begin
      adr_map_s = adr_map_s | (adr_idx_s == IDX_W'(c));
      rd_dat_s  = rd_dat_s | ({32{adr_idx_s == IDX_W'(c)}} &
                  ((wb_adr_i[2] == 1'(STATUS_OFS)) ? status_s[c] : chan_areg_o[32*c +: 32]));
    end
  end

  // Transfer-in-progress flags: set on acceptance, cleared on ack/err.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rip_r <= 1'b0;
      wip_r <= 1'b0;
    end else begin
      if (rd_req_s) begin
        rip_r <= 1'b1;
      end else if (done_s) begin
        rip_r <= 1'b0;
      end
      if (wr_req_s) begin
        wip_r <= 1'b1;
      end else if (done_s) begin
        wip_r <= 1'b0;
      end
    end
  end

  // d0 stage: captures a write request for application on the next edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d0_vld_r  <= 1'b0;
      d0_map_r  <= 1'b0;
      d0_word_r <= 1'b0;
      d0_idx_r  <= '0;
      d0_dat_r  <= 32'd0;
    end else begin
      d0_vld_r <= wr_req_s;
      if (wr_req_s) begin
        d0_map_r  <= adr_map_s;
        d0_word_r <= wb_adr_i[2];
        d0_idx_r  <= adr_idx_s;
        d0_dat_r  <= wb_dat_i;
      end
    end
  end

  // Response: single-cycle ack or err, read data held between reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= (rd_req_s & adr_map_s) | (d0_vld_r & d0_map_r);
      err_r <= (rd_req_s & ~adr_map_s) | (d0_vld_r & ~d0_map_r);
      if (rd_req_s) begin
        dat_r <= adr_map_s ? rd_dat_s : 32'd0;
      end else if (d0_vld_r & ~d0_map_r) begin
        dat_r <= 32'd0;
      end
    end
  end

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    assign areg_we_s[c]   = d0_vld_r & d0_map_r & (d0_idx_r == IDX_W'(c)) &
                            (d0_word_r == 1'(AREG_OFS));
    assign status_we_s[c] = d0_vld_r & d0_map_r & (d0_idx_r == IDX_W'(c)) &
                            (d0_word_r == 1'(STATUS_OFS));

    repeat_iogroup_bank_chan #(
      .AREG_RST (AREG_RST)
    ) u_chan (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .areg_we   (areg_we_s[c]),
      .status_we (status_we_s[c]),
      .wdat      (d0_dat_r),
      .evt       (chan_evt_i[2*c +: 2]),
      .areg      (chan_areg_o[32*c +: 32]),
      .areg_wr   (chan_areg_wr_o[c]),
      .status    (status_s[c]),
      .sticky    (sticky_s[2*c +: 2])
    );
  end

`ifdef REPEAT_IOGROUP_BANK_IRQ_EN
  logic irq_r;

  // Interrupt: registered OR of every sticky flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |sticky_s;
    end
  end

  assign irq_o = irq_r;
`else
  logic unused_sticky_s;
  assign unused_sticky_s = |sticky_s;
`endif

endmodule

// File: tb/tb_repeat_iogroup_bank.sv
// Self-checking bench for repeat_iogroup_bank (N_CHAN=3 so words 6/7 are
// unmapped). Table-driven accesses plus hand sequences for W1C, set/clear
// collision and reset in the middle of a write; responses are checked by a
// scoreboard queue filled when each request is driven.
module tb_repeat_iogroup_bank;

  localparam int          NC    = 3;
  localparam logic [31:0] RST_V = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [2:0]  adr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic        ack, err, rty, stall;
  logic [31:0] rdat;
  logic [32*NC-1:0] areg;
  logic [NC-1:0]    areg_wr;
  logic [2*NC-1:0]  evt;
`ifdef REPEAT_IOGROUP_BANK_IRQ_EN
  logic        irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic        chk_dat;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic        exp_err;
    logic [31:0] exp_dat;
    logic [2:0]  exp_wr;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  repeat_iogroup_bank #(
    .N_CHAN   (NC),
    .AREG_RST (RST_V)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .wb_cyc_i       (cyc),
    .wb_stb_i       (stb),
    .wb_adr_i       (adr),
    .wb_sel_i       (sel),
    .wb_we_i        (we),
    .wb_dat_i       (wdat),
    .wb_ack_o       (ack),
    .wb_err_o       (err),
    .wb_rty_o       (rty),
    .wb_stall_o     (stall),
    .wb_dat_o       (rdat),
    .chan_areg_o    (areg),
    .chan_areg_wr_o (areg_wr),
    .chan_evt_i     (evt)
`ifdef REPEAT_IOGROUP_BANK_IRQ_EN
    ,
    .irq_o          (irq)
`endif
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every ack/err must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ack === 1'b1 || err === 1'b1)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", {94'd0, ack, err}, 96'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_err", {95'd0, err}, {95'd0, mon_e.err});
        chk("resp_ack", {95'd0, ack}, {95'd0, ~mon_e.err});
        if (mon_e.chk_dat) begin
          chk("resp_dat", {64'd0, rdat}, {64'd0, mon_e.dat});
        end
      end
    end
  end

  // One Wishbone access; optionally changes evt on wait cycle inj_cyc.
  task automatic wb_access(input logic w, input logic [2:0] a, input logic [31:0] d,
                           input logic e_err, input logic [31:0] e_dat, input logic [2:0] e_wr,
                           input int inj_cyc, input logic [5:0] inj_evt);
    bit seen;
    @(negedge clk);
    sb_q.push_back('{e_err, e_dat, (~w) | e_err});
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    #1;
    chk("stall_req", {95'd0, stall}, {95'd0, 1'b1});
    seen = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (k == inj_cyc) evt = inj_evt;
      if (ack === 1'b1 || err === 1'b1) begin
        seen = 1'b1;
        chk("latency", 96'(k), 96'(w ? 2 : 1));
        chk("areg_wr", {93'd0, areg_wr}, {93'd0, e_wr});
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no ack/err for adr %0d", a);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    wb_access(1'b0, a, 32'd0, 1'b0, e, 3'b000, 0, 6'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [2:0] e_wr);
    wb_access(1'b1, a, d, 1'b0, 32'd0, e_wr, 0, 6'd0);
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 3'd0; sel = 4'hF; wdat = 32'd0; evt = 6'd0;

    for (int i = 0; i < 6; i++) begin
      tbl[i] = '{1'b0, 3'(i), 32'd0, 1'b0, ((i % 2) == 0) ? RST_V : 32'd0, 3'b000};
    end
    tbl[6]  = '{1'b0, 3'd6, 32'd0,         1'b1, 32'd0,         3'b000};
    tbl[7]  = '{1'b0, 3'd7, 32'd0,         1'b1, 32'd0,         3'b000};
    tbl[8]  = '{1'b1, 3'd4, 32'hDEADBEEF,  1'b0, 32'd0,         3'b100};
    tbl[9]  = '{1'b0, 3'd4, 32'd0,         1'b0, 32'hDEADBEEF,  3'b000};
    tbl[10] = '{1'b1, 3'd0, 32'h0000_00FF, 1'b0, 32'd0,         3'b001};
    tbl[11] = '{1'b0, 3'd0, 32'd0,         1'b0, 32'h0000_00FF, 3'b000};
    tbl[12] = '{1'b1, 3'd6, 32'h0000_0055, 1'b1, 32'd0,         3'b000};
    tbl[13] = '{1'b0, 3'd2, 32'd0,         1'b0, RST_V,         3'b000};
    tbl[14] = '{1'b0, 3'd4, 32'd0,         1'b0, 32'hDEADBEEF,  3'b000};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack",  {95'd0, ack}, 96'd0);
    chk("rst_err",  {95'd0, err}, 96'd0);
    chk("rst_rty",  {95'd0, rty}, 96'd0);
    chk("rst_dat",  {64'd0, rdat}, 96'd0);
    chk("rst_wr",   {93'd0, areg_wr}, 96'd0);
    chk("rst_areg", areg, {RST_V, RST_V, RST_V});
`ifdef REPEAT_IOGROUP_BANK_IRQ_EN
    chk("rst_irq", {95'd0, irq}, 96'd0);
`endif

    for (int i = 0; i < 15; i++) begin
      wb_access(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].exp_err,
                tbl[i].exp_dat, tbl[i].exp_wr, 0, 6'd0);
    end
    chk("areg_after_tbl", areg, {32'hDEADBEEF, RST_V, 32'h0000_00FF});

    // Channel 1 f0 pulse -> sticky bit 2; W1C behaviour.
    @(negedge clk); evt = 6'b000100;
    @(negedge clk); evt = 6'b000000;
    @(negedge clk);
`ifdef REPEAT_IOGROUP_BANK_IRQ_EN
    chk("irq_set", {95'd0, irq}, {95'd0, 1'b1});
`endif
    rd(3'd3, 32'h4);
    wr(3'd3, 32'h0, 3'b000);
    rd(3'd3, 32'h4);
    wr(3'd3, 32'h4, 3'b000);
`ifdef REPEAT_IOGROUP_BANK_IRQ_EN
    chk("irq_hold_at_clear", {95'd0, irq}, {95'd0, 1'b1});
    @(negedge clk);
    chk("irq_drop", {95'd0, irq}, 96'd0);
`endif
    rd(3'd3, 32'h0);

    // Channel 1 f1 held high: live bit 1 plus sticky bit 3.
    evt = 6'b001000;
    rd(3'd3, 32'hA);
    wr(3'd3, 32'h8, 3'b000);
    rd(3'd3, 32'h2);

    // Rising edge on f1 in the same cycle as the W1C of bit 3: set wins.
    evt = 6'b000000;
    wb_access(1'b1, 3'd3, 32'h8, 1'b0, 32'd0, 3'b000, 1, 6'b001000);
    rd(3'd3, 32'hA);
    evt = 6'b000000;
    wr(3'd3, 32'h8, 3'b000);
    rd(3'd3, 32'h0);

    // Reset asserted while the write sits in the d0 stage.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd2; wdat = 32'hCAFE_F00D;
    @(negedge clk);
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {93'd0, ack, err, areg_wr}, 96'd0);
    end
    chk("post_rst_areg", areg, {RST_V, RST_V, RST_V});
    rd(3'd2, RST_V);
    rd(3'd3, 32'h0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 96'(sb_q.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
